uart_ptc_master: RTL and testbench
==================================

// Module: uart_ptc_master
// PURPOSE
// Host-side initiator of the fixed-length UART command protocol. Accepts a request payload,
// frames it as [CMD_HDR | payload | checksum], and hands it to an n-byte UART sender.
// It then waits for the BRN-byte response from an n-byte UART receiver, checks its header
// and checksum, and retries on error or timeout. It sits between host logic and the
// uart_send_nbytes/uart_recv_nbytes pair, as the peer of the board-side protocol responder.
// PARAMETERS
// BSN        4      command frame length in bytes (>=3)
// BRN        4      response frame length in bytes (>=3)
// CLK_FRE    50     sys_clk frequency, MHz
// TIMEOUT_US 10000  response timeout per attempt, microseconds
// MAX_RETRY  2      extra attempts after the first (0 = single attempt)
// CMD_HDR    8'hAA  command header byte
// RSP_HDR    8'h55  response header byte
// PORTS
// sys_clk            in   1            system clock
// rst                in   1            async reset, active-high
// req_valid          in   1            request strobe
// req_ready          out  1            high only in IDLE
// req_payload        in   (BSN-2)*8    command payload, MSB byte sent first
// uart_send_flag     out  1            one-cycle pulse to sender
// dataT              out  BSN*8        framed command; byte0 = dataT[BSN*8-1 -: 8]
// uart_send_comlete  in   1            sender done pulse
// uart_recv_flag     in   1            receiver frame-complete pulse
// dataR              in   BRN*8        received frame; byte0 = dataR[BRN*8-1 -: 8]
// rsp_valid          out  1            one-cycle result pulse
// rsp_payload        out  (BRN-2)*8    response payload bytes 1..BRN-2
// rsp_status         out  2            00 ok, 01 bad header/checksum, 10 timeout
// busy               out  1            high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE; uart_send_flag, rsp_valid and busy are 0; req_ready=1;
//   dataT, rsp_payload and rsp_status are 0; retry and timeout counters are 0.
// - Checksum: 8-bit sum, modulo 256, of all preceding frame bytes (header included).
// - IDLE: on req_valid & req_ready, latch req_payload and clear the retry count; go to BUILD.
// - BUILD (1 cycle): register dataT = {CMD_HDR, payload, checksum}; go to SEND.
// - SEND (1 cycle): uart_send_flag=1; go to WAIT_TX. First pulse comes 2 cycles after acceptance.
// - WAIT_TX: wait for uart_send_comlete, then go to WAIT_RX and clear the timeout counter.
//   No timeout applies in WAIT_TX. A uart_recv_flag seen here is stale and is ignored.
// - WAIT_RX: count up to CLK_FRE*TIMEOUT_US-1.
//   uart_recv_flag: latch dataR, go to CHECK.
//   Terminal count: timeout error, go to RETRY.
//   If uart_recv_flag and terminal count occur in the same cycle, the frame wins.
// - CHECK (1 cycle): byte0==RSP_HDR and last byte==checksum(bytes 0..BRN-2) -> status 00, DONE.
//   Otherwise -> status 01, RETRY.
// - RETRY: if retry_cnt<MAX_RETRY, increment retry_cnt and go to SEND. dataT is unchanged
//   and not rebuilt. Otherwise go to DONE with the last error status.
// - DONE (1 cycle): rsp_valid=1, then IDLE. rsp_payload/rsp_status hold until the next DONE.
//   On error, rsp_payload holds the last received bytes, or is unchanged if nothing was received.
// - uart_send_comlete or uart_recv_flag outside its wait state: ignored, no state change.
// - req_valid while busy: not accepted (req_ready=0); the request is not queued.
// - Reset mid-transaction: immediate return to IDLE with reset values; no pulse is emitted.
// - Timeout counter width: $clog2(CLK_FRE*TIMEOUT_US+1); the counter saturates and never wraps.
// TESTING
// (sim params: BSN=BRN=4, CLK_FRE=50, TIMEOUT_US=1 -> 50-cycle timeout, MAX_RETRY=2)
// 1 req_payload=16'h1234 -> dataT=32'hAA1234F0, one uart_send_flag pulse 2 cycles after accept.
// 2 after send complete, dataR=32'h55ABCDCD + recv_flag -> rsp_valid, payload 16'hABCD, status 00.
// 3 response 32'h55ABCD00 every attempt -> 3 send pulses, then rsp_valid, status 01.
// 4 no response -> 3 sends, each followed by 50 idle cycles, then rsp_valid, status 10.
// 5 recv_flag on the timeout-terminal cycle with a good frame -> status 00, no retry.
// 6 assert rst during WAIT_RX -> all outputs at reset values; next request runs normally.

Source files
------------

// File: rtl/uart_ptc_if.sv
// Host-side bundle between the request/response client and the UART command master.
// Carries the request handshake, the n-byte UART sender/receiver hooks and the result strobe.
interface uart_ptc_if #(
  parameter int BSN = 4,
  parameter int BRN = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [(BSN-2)*8-1:0]   req_payload;
  logic                   uart_send_flag;
  logic [BSN*8-1:0]       dataT;
  logic                   uart_send_comlete;
  logic                   uart_recv_flag;
  logic [BRN*8-1:0]       dataR;
  logic                   rsp_valid;
  logic [(BRN-2)*8-1:0]   rsp_payload;
  logic [1:0]             rsp_status;
  logic                   busy;

  modport master (
    input  req_valid,
    input  req_payload,
    input  uart_send_comlete,
    input  uart_recv_flag,
    input  dataR,
    output req_ready,
    output uart_send_flag,
    output dataT,
    output rsp_valid,
    output rsp_payload,
    output rsp_status,
    output busy
  );

  modport slave (
    output req_valid,
    output req_payload,
    output uart_send_comlete,
    output uart_recv_flag,
    output dataR,
    input  req_ready,
    input  uart_send_flag,
    input  dataT,
    input  rsp_valid,
    input  rsp_payload,
    input  rsp_status,
    input  busy
  );
endinterface

// File: rtl/uart_ptc_master.sv
// Fixed-length UART command initiator: frames a request, sends it, and
// validates the response with header/checksum checks, timeout and retries.
module uart_ptc_master #(
  parameter int         BSN        = 4,
  parameter int         BRN        = 4,
  parameter int         CLK_FRE    = 50,
  parameter int         TIMEOUT_US = 10000,
  parameter int         MAX_RETRY  = 2,
  parameter logic [7:0] CMD_HDR    = 8'hAA,
  parameter logic [7:0] RSP_HDR    = 8'h55
) (
  input  logic     sys_clk,
  input  logic     rst,
  uart_ptc_if.master bus
);

  localparam int PW  = (BSN-2)*8;
  localparam int RPW = (BRN-2)*8;
  localparam int TMO = CLK_FRE*TIMEOUT_US;
  localparam int TW  = $clog2(TMO+1);
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;

  typedef enum logic [2:0] {
    IDLE, BUILD, SEND, WAIT_TX,
    WAIT_RX, CHECK, RETRY, DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    pay_q;
  logic [BRN*8-1:0] rx_q;
  logic             rx_seen;
  logic [1:0]       err;
  logic [RW-1:0]    retry_cnt;
  logic [TW-1:0]    tmo_cnt;

  logic             req_ready;
  logic             send_flag;
  logic [BSN*8-1:0] data_t;
  logic             rsp_valid;
  logic [RPW-1:0]   rsp_payload;
  logic [1:0]       rsp_status;
  logic             busy;

  logic [7:0]       tx_sum;
  logic [7:0]       rx_sum;
  logic             rx_ok;
  logic [RPW-1:0]   rx_mid;

  assign bus.req_ready      = req_ready;
  assign bus.uart_send_flag = send_flag;
  assign bus.dataT          = data_t;
  assign bus.rsp_valid      = rsp_valid;
  assign bus.rsp_payload    = rsp_payload;
  assign bus.rsp_status     = rsp_status;
  assign bus.busy           = busy;

  always_comb begin
    tx_sum = CMD_HDR;
    for (int i = 0; i < BSN-2; i++)
      tx_sum = tx_sum + pay_q[PW-1-8*i -: 8];
  end

  // Sum covers header and payload; the last byte is the checksum itself.
  always_comb begin
    rx_sum = 8'h00;
    for (int i = 0; i < BRN-1; i++)
      rx_sum = rx_sum + rx_q[BRN*8-1-8*i -: 8];
  end

  assign rx_ok  = (rx_q[BRN*8-1 -: 8] == RSP_HDR) &&
                  (rx_q[7:0] == rx_sum);
  assign rx_mid = rx_q[BRN*8-9 -: RPW];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pay_q       <= '0;
      rx_q        <= '0;
      rx_seen     <= 1'b0;
      err         <= 2'b00;
      retry_cnt   <= '0;
      tmo_cnt     <= '0;
      req_ready   <= 1'b1;
      send_flag   <= 1'b0;
      data_t      <= '0;
      rsp_valid   <= 1'b0;
      rsp_payload <= '0;
      rsp_status  <= 2'b00;
      busy        <= 1'b0;
    end else begin
      send_flag <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid && req_ready) begin
            pay_q     <= bus.req_payload;
            retry_cnt <= '0;
            rx_seen   <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= BUILD;
          end
        end
        BUILD: begin
          data_t    <= {CMD_HDR, pay_q, tx_sum};
          send_flag <= 1'b1;
          state     <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (bus.uart_send_comlete) begin
            tmo_cnt <= '0;
            state   <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          // A frame arriving on the terminal cycle still counts.
          if (bus.uart_recv_flag) begin
            rx_q    <= bus.dataR;
            rx_seen <= 1'b1;
            state   <= CHECK;
          end else if (tmo_cnt == TW'(TMO-1)) begin
            err   <= 2'b10;
            state <= RETRY;
          end else if (tmo_cnt != TW'(TMO)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (rx_ok) begin
            err         <= 2'b00;
            rsp_status  <= 2'b00;
            rsp_payload <= rx_mid;
            rsp_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            err   <= 2'b01;
            state <= RETRY;
          end
        end
        RETRY: begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            send_flag <= 1'b1;
            state     <= SEND;
          end else begin
            rsp_status <= err;
            if (rx_seen) rsp_payload <= rx_mid;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ptc_master.sv
// Bench for uart_ptc_master: vector table plus hand sequences for the
// timeout-terminal race and mid-transaction reset, with a result scoreboard.
module tb_uart_ptc_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_ptc_if #(.BSN(4), .BRN(4)) bus ();

  uart_ptc_master #(
    .BSN(4), .BRN(4), .CLK_FRE(50), .TIMEOUT_US(1),
    .MAX_RETRY(2), .CMD_HDR(8'hAA), .RSP_HDR(8'h55)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] payload;
    logic [31:0] data_t;
    int          mode;
    logic [31:0] frame;
    logic [1:0]  status;
    logic [15:0] rpay;
    int          sends;
  } vec_t;

  typedef struct {
    logic [1:0]  status;
    logic [15:0] rpay;
    int          sends;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got none expected event", nm);
  endtask

  task automatic pop_check(input int sends);
    exp_t e;
    if (sb.size() == 0) begin
      fail("sb_empty");
    end else begin
      e = sb.pop_front();
      chk("rsp_status", bus.rsp_status, e.status);
      chk("rsp_payload", bus.rsp_payload, e.rpay);
      chk("send_count", sends, e.sends);
    end
  endtask

  task automatic run(input vec_t v);
    int   n;
    int   sends;
    exp_t e;
    chk("ready_idle", bus.req_ready, 1);
    e = '{v.status, v.rpay, v.sends};
    sb.push_back(e);
    bus.req_payload = v.payload;
    bus.req_valid   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) bus.req_valid = 1'b0;
    end while (!bus.uart_send_flag && n < 20);
    chk("send_latency", n, 2);
    sends = 0;
    while (bus.uart_send_flag) begin
      sends++;
      chk("dataT", bus.dataT, v.data_t);
      tick();
      bus.uart_send_comlete = 1'b1;
      tick();
      bus.uart_send_comlete = 1'b0;
      if (v.mode != 2) begin
        bus.dataR          = v.frame;
        bus.uart_recv_flag = 1'b1;
        tick();
        bus.uart_recv_flag = 1'b0;
      end
      n = 0;
      while (!bus.uart_send_flag && !bus.rsp_valid && n < 200) begin
        tick();
        n++;
      end
      if (v.mode == 2) chk("timeout_gap", n, 51);
    end
    if (!bus.rsp_valid) begin
      fail("rsp_wait");
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      pop_check(sends);
      tick();
      chk("rsp_pulse", bus.rsp_valid, 0);
      chk("ready_after", bus.req_ready, 1);
      chk("busy_after", bus.busy, 0);
    end
  endtask

  initial begin
    int   n;
    int   sends;
    exp_t e;

    bus.req_valid         = 1'b0;
    bus.req_payload       = '0;
    bus.uart_send_comlete = 1'b0;
    bus.uart_recv_flag    = 1'b0;
    bus.dataR             = '0;

    // payload, dataT, mode(0 good,1 bad,2 silent), frame, status, rsp_payload, sends
    vecs[0] = '{16'h1234, 32'hAA1234F0, 0, 32'h55ABCDCD, 2'b00, 16'hABCD, 1};
    vecs[1] = '{16'h1234, 32'hAA1234F0, 1, 32'h55ABCD00, 2'b01, 16'hABCD, 3};
    vecs[2] = '{16'h5A5A, 32'hAA5A5A5E, 2, 32'h0,        2'b10, 16'hABCD, 3};
    vecs[3] = '{16'hFFFF, 32'hAAFFFFA8, 0, 32'h55010258, 2'b00, 16'h0102, 1};
    vecs[4] = '{16'h0000, 32'hAA0000AA, 1, 32'h54010257, 2'b01, 16'h0102, 3};
    vecs[5] = '{16'h0001, 32'hAA0001AB, 2, 32'h0,        2'b10, 16'h0102, 3};

    tick();
    tick();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_flag", bus.uart_send_flag, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_dataT", bus.dataT, 0);
    chk("rst_rsp", {bus.rsp_status, bus.rsp_payload}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Frame lands on the timeout-terminal cycle; a request while busy is dropped.
    e = '{2'b00, 16'hABCD, 1};
    sb.push_back(e);
    bus.req_payload = 16'h1234;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.uart_send_flag && n < 20) begin
      tick();
      n++;
    end
    sends = bus.uart_send_flag ? 1 : 0;
    tick();
    bus.uart_send_comlete = 1'b1;
    tick();
    bus.uart_send_comlete = 1'b0;
    for (int i = 0; i < 49; i++) begin
      if (i == 10) begin
        chk("busy_ready", bus.req_ready, 0);
        bus.req_payload = 16'h9999;
        bus.req_valid   = 1'b1;
      end
      if (i == 12) bus.req_valid = 1'b0;
      tick();
    end
    bus.dataR          = 32'h55ABCDCD;
    bus.uart_recv_flag = 1'b1;
    tick();
    bus.uart_recv_flag = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      tick();
      n++;
      if (bus.uart_send_flag) sends++;
    end
    if (!bus.rsp_valid) begin
      fail("race_rsp_wait");
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      pop_check(sends);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.uart_send_flag) n++;
    end
    chk("no_queued_req", n, 0);

    // Reset asserted while waiting for the response.
    bus.req_payload = 16'h4321;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.uart_send_flag && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.uart_send_comlete = 1'b1;
    tick();
    bus.uart_send_comlete = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_dataT", bus.dataT, 0);
    chk("mid_rst_rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_payload}, 0);
    chk("mid_rst_flag", bus.uart_send_flag, 0);
    tick();
    rst = 1'b0;
    tick();
    run(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
